video_timing_gen: RTL and testbench

Parametrised successor to the single-axis horizontal sync counter. It generates horizontal and vertical timing in one block, with configurable porch and sync lengths, selectable sync polarity, a pixel clock-enable, soft restart and a frame counter. It feeds the color/pixel pipeline with x/y coordinates, blank/de and line/frame strobes, and drives the VGA connector sync pins directly. The defaults give 800x600@72 Hz from the 50 MHz clock.

---
 rtl/video_timing_gen.sv | 109 ++++++++++
 tb/tb_video_timing_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Horizontal/vertical video timing generator: x/y counters, registered sync/blank
// decode, line/frame strobes, soft restart and a completed-frame counter.
module video_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int FW       = 8
) (
  input  logic          clk50,
  input  logic          rst_n,
  input  logic          en,
  input  logic          restart,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          blank_out,
  output logic          de_out,
  output logic [CW-1:0] x_crd,
  output logic [CW-1:0] y_crd,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] hcnt_nxt, vcnt_nxt;
  logic          frame_inc;
  logic          restart_pend;
  logic          h_blank_nxt, v_blank_nxt;
  logic          h_sync_nxt, v_sync_nxt;

  always_comb begin
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    frame_inc = 1'b0;
    if (en) begin
      // A pending restart wins over the natural wrap and suppresses the frame count.
      if (restart_pend) begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
      end else if (hcnt == H_LAST) begin
        hcnt_nxt = '0;
        if (vcnt == V_LAST) begin
          vcnt_nxt  = '0;
          frame_inc = 1'b1;
        end else begin
          vcnt_nxt = vcnt + CW'(1);
        end
      end else begin
        hcnt_nxt = hcnt + CW'(1);
      end
    end
  end

  // Decode the next position so the registered syncs line up with x_crd/y_crd.
  always_comb begin
    h_blank_nxt = (hcnt_nxt >= H_ACT_END);
    v_blank_nxt = (vcnt_nxt >= V_ACT_END);
    h_sync_nxt  = (hcnt_nxt >= H_SYNC_BEG) && (hcnt_nxt < H_SYNC_END);
    v_sync_nxt  = (vcnt_nxt >= V_SYNC_BEG) && (vcnt_nxt < V_SYNC_END);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt         <= '0;
      vcnt         <= '0;
      frame_cnt    <= '0;
      restart_pend <= 1'b0;
      hsync_out    <= ~H_POL;
      vsync_out    <= ~V_POL;
      blank_out    <= 1'b0;
    end else begin
      hcnt         <= hcnt_nxt;
      vcnt         <= vcnt_nxt;
      restart_pend <= restart | (restart_pend & ~en);
      if (frame_inc) frame_cnt <= frame_cnt + FW'(1);
      hsync_out    <= h_sync_nxt ? H_POL : ~H_POL;
      vsync_out    <= v_sync_nxt ? V_POL : ~V_POL;
      blank_out    <= h_blank_nxt | v_blank_nxt;
    end
  end

  assign de_out      = ~blank_out;
  assign x_crd       = hcnt;
  assign y_crd       = vcnt;
  // Gated by rst_n so the strobes stay low for the whole reset.
  assign line_start  = rst_n & en & (hcnt == '0);
  assign frame_start = rst_n & en & (hcnt == '0) & (vcnt == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: dut_a default timing, dut_b tiny inverted-polarity timing,
// dut_c medium timing (H 16/2/3/3 = 24, V 10/2/2/2 = 16) for frame-level checks.
module tb_video_timing_gen;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk50 = ~clk50;

  int tests = 0;
  int fails = 0;

  logic        en_a = 0, restart_a = 0;
  logic        hs_a, vs_a, bl_a, de_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;
  logic [7:0]  fc_a;

  logic        en_b = 0, restart_b = 0;
  logic        hs_b, vs_b, bl_b, de_b, ls_b, fs_b;
  logic [3:0]  x_b, y_b;
  logic [7:0]  fc_b;

  logic        en_c = 0, restart_c = 0;
  logic        hs_c, vs_c, bl_c, de_c, ls_c, fs_c;
  logic [10:0] x_c, y_c;
  logic [7:0]  fc_c;

  video_timing_gen dut_a (
    .clk50(clk50), .rst_n(rst_n), .en(en_a), .restart(restart_a),
    .hsync_out(hs_a), .vsync_out(vs_a), .blank_out(bl_a), .de_out(de_a),
    .x_crd(x_a), .y_crd(y_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  video_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .clk50(clk50), .rst_n(rst_n), .en(en_b), .restart(restart_b),
    .hsync_out(hs_b), .vsync_out(vs_b), .blank_out(bl_b), .de_out(de_b),
    .x_crd(x_b), .y_crd(y_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_c (
    .clk50(clk50), .rst_n(rst_n), .en(en_c), .restart(restart_c),
    .hsync_out(hs_c), .vsync_out(vs_c), .blank_out(bl_c), .de_out(de_c),
    .x_crd(x_c), .y_crd(y_c), .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
  );

  task automatic tick();
    @(posedge clk50);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    en_a = 0; en_b = 0; en_c = 0;
    restart_a = 0; restart_b = 0; restart_c = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    en_a = 1;
    repeat (2) tick();
    tests++; if (x_a !== 11'd0 || y_a !== 11'd0) begin fails++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x_a, y_a); end
    tests++; if (hs_a !== 1'b0 || vs_a !== 1'b0) begin fails++; $display("FAIL reset_sync: got hs=%b vs=%b want 0,0", hs_a, vs_a); end
    tests++; if (bl_a !== 1'b0 || de_a !== 1'b1) begin fails++; $display("FAIL reset_blank: got bl=%b de=%b want 0,1", bl_a, de_a); end
    tests++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin fails++; $display("FAIL reset_strobe: got ls=%b fs=%b want 0,0", ls_a, fs_a); end
    tests++; if (fc_a !== 8'd0) begin fails++; $display("FAIL reset_fcnt: got %0d want 0", fc_a); end
    tests++; if (hs_b !== 1'b1 || vs_b !== 1'b1) begin fails++; $display("FAIL reset_sync_lowpol: got hs=%b vs=%b want 1,1", hs_b, vs_b); end
    en_a = 0;
    rst_n = 1;
  endtask

  task automatic test_hline();
    int ex, ey;
    do_reset();
    en_a = 1;
    #1;
    for (int i = 0; i <= 2080; i++) begin
      ex = i % 1040;
      ey = i / 1040;
      tests++; if (x_a !== 11'(ex) || y_a !== 11'(ey)) begin fails++; $display("FAIL hline_xy: got %0d,%0d want %0d,%0d", x_a, y_a, ex, ey); end
      tests++; if (ls_a !== (ex == 0)) begin fails++; $display("FAIL hline_ls at x=%0d: got %b want %b", ex, ls_a, ex == 0); end
      tests++; if (bl_a !== (ex >= 800) || de_a !== (ex < 800)) begin fails++; $display("FAIL hline_blank at x=%0d: got bl=%b de=%b", ex, bl_a, de_a); end
      tests++; if (hs_a !== (ex >= 856 && ex < 976)) begin fails++; $display("FAIL hline_hsync at x=%0d: got %b want %b", ex, hs_a, ex >= 856 && ex < 976); end
      tick();
    end
    en_a = 0;
  endtask

  task automatic test_frame();
    int ex, ey, efc, n_ls;
    logic prev_vs;
    do_reset();
    ex = 0; ey = 0; efc = 0; n_ls = 0;
    en_c = 1;
    #1;
    prev_vs = vs_c;
    for (int cyc = 0; cyc < 384; cyc++) begin
      tests++; if (x_c !== 11'(ex) || y_c !== 11'(ey) || fc_c !== 8'(efc)) begin fails++; $display("FAIL frame_pos: got %0d,%0d fc=%0d want %0d,%0d fc=%0d", x_c, y_c, fc_c, ex, ey, efc); end
      tests++; if (vs_c !== (ey >= 12 && ey < 14)) begin fails++; $display("FAIL frame_vsync at y=%0d: got %b", ey, vs_c); end
      tests++; if (hs_c !== (ex >= 18 && ex < 21)) begin fails++; $display("FAIL frame_hsync at x=%0d: got %b", ex, hs_c); end
      tests++; if (bl_c !== (ex >= 16 || ey >= 10)) begin fails++; $display("FAIL frame_blank at %0d,%0d: got %b", ex, ey, bl_c); end
      tests++; if (fs_c !== (ex == 0 && ey == 0)) begin fails++; $display("FAIL frame_fs at %0d,%0d: got %b", ex, ey, fs_c); end
      tests++; if (vs_c !== prev_vs && ex != 0) begin fails++; $display("FAIL frame_vs_edge: vsync changed at x=%0d", ex); end
      prev_vs = vs_c;
      if (ls_c === 1'b1) n_ls++;
      tick();
      if (ex == 23) begin
        ex = 0;
        if (ey == 15) begin ey = 0; efc++; end else ey++;
      end else ex++;
    end
    tests++; if (n_ls != 16) begin fails++; $display("FAIL frame_ls_count: got %0d want 16", n_ls); end
    tests++; if (x_c !== 11'd0 || y_c !== 11'd0 || fs_c !== 1'b1) begin fails++; $display("FAIL frame_period: got %0d,%0d fs=%b want 0,0,1", x_c, y_c, fs_c); end
    tests++; if (fc_c !== 8'd1) begin fails++; $display("FAIL frame_fcnt: got %0d want 1", fc_c); end
    en_c = 0;
  endtask

  task automatic test_en_toggle();
    int ex, ey, efc;
    do_reset();
    ex = 0; ey = 0; efc = 0;
    for (int cyc = 0; cyc < 768; cyc++) begin
      en_c = (cyc % 2 == 0);
      #1;
      tests++; if (x_c !== 11'(ex) || y_c !== 11'(ey) || fc_c !== 8'(efc)) begin fails++; $display("FAIL en_pos cyc %0d: got %0d,%0d fc=%0d want %0d,%0d fc=%0d", cyc, x_c, y_c, fc_c, ex, ey, efc); end
      if (!en_c) begin
        tests++; if (ls_c !== 1'b0 || fs_c !== 1'b0) begin fails++; $display("FAIL en_strobe_gated cyc %0d: got ls=%b fs=%b want 0,0", cyc, ls_c, fs_c); end
      end else begin
        tests++; if (ls_c !== (ex == 0)) begin fails++; $display("FAIL en_ls cyc %0d: got %b want %b", cyc, ls_c, ex == 0); end
      end
      tick();
      if (en_c) begin
        if (ex == 23) begin
          ex = 0;
          if (ey == 15) begin ey = 0; efc++; end else ey++;
        end else ex++;
      end
    end
    en_c = 1;
    #1;
    tests++; if (x_c !== 11'd0 || y_c !== 11'd0 || fc_c !== 8'd1 || fs_c !== 1'b1) begin fails++; $display("FAIL en_period: got %0d,%0d fc=%0d fs=%b want 0,0,1,1", x_c, y_c, fc_c, fs_c); end
    en_c = 0;
  endtask

  task automatic test_restart();
    do_reset();
    en_c = 1;
    repeat (130) tick();
    tests++; if (x_c !== 11'd10 || y_c !== 11'd5) begin fails++; $display("FAIL rst_pre: got %0d,%0d want 10,5", x_c, y_c); end
    restart_c = 1;
    tick();
    restart_c = 0;
    tests++; if (x_c !== 11'd11 || y_c !== 11'd5) begin fails++; $display("FAIL rst_deferred: got %0d,%0d want 11,5", x_c, y_c); end
    tick();
    tests++; if (x_c !== 11'd0 || y_c !== 11'd0 || fs_c !== 1'b1) begin fails++; $display("FAIL rst_load: got %0d,%0d fs=%b want 0,0,1", x_c, y_c, fs_c); end
    tests++; if (fc_c !== 8'd0) begin fails++; $display("FAIL rst_fcnt: got %0d want 0", fc_c); end
    repeat (382) tick();
    tests++; if (x_c !== 11'd22 || y_c !== 11'd15) begin fails++; $display("FAIL rst_wrap_pre: got %0d,%0d want 22,15", x_c, y_c); end
    restart_c = 1;
    tick();
    restart_c = 0;
    tick();
    tests++; if (x_c !== 11'd0 || y_c !== 11'd0 || fc_c !== 8'd0) begin fails++; $display("FAIL rst_wrap: got %0d,%0d fc=%0d want 0,0,0", x_c, y_c, fc_c); end
    repeat (2) tick();
    en_c = 0;
    restart_c = 1;
    tick();
    restart_c = 0;
    repeat (2) tick();
    tests++; if (x_c !== 11'd2 || ls_c !== 1'b0) begin fails++; $display("FAIL rst_hold: got x=%0d ls=%b want 2,0", x_c, ls_c); end
    en_c = 1;
    tick();
    tests++; if (x_c !== 11'd0 || y_c !== 11'd0 || fc_c !== 8'd0) begin fails++; $display("FAIL rst_pend_en: got %0d,%0d fc=%0d want 0,0,0", x_c, y_c, fc_c); end
    en_c = 0;
  endtask

  task automatic test_small_pol();
    int ex, ey;
    do_reset();
    ex = 0; ey = 0;
    en_b = 1;
    for (int cyc = 0; cyc < 99; cyc++) begin
      tests++; if (x_b !== 4'(ex) || y_b !== 4'(ey)) begin fails++; $display("FAIL pol_pos: got %0d,%0d want %0d,%0d", x_b, y_b, ex, ey); end
      tests++; if (hs_b !== !(ex >= 10 && ex < 12)) begin fails++; $display("FAIL pol_hsync at x=%0d: got %b", ex, hs_b); end
      tests++; if (vs_b !== (ey != 5)) begin fails++; $display("FAIL pol_vsync at y=%0d: got %b", ey, vs_b); end
      tests++; if (bl_b !== (ex >= 8 || ey >= 4) || de_b !== !(ex >= 8 || ey >= 4)) begin fails++; $display("FAIL pol_blank at %0d,%0d: got bl=%b de=%b", ex, ey, bl_b, de_b); end
      tick();
      if (ex == 13) begin
        ex = 0;
        ey = (ey == 6) ? 0 : ey + 1;
      end else ex++;
    end
    tests++; if (fc_b !== 8'd1) begin fails++; $display("FAIL pol_fcnt: got %0d want 1", fc_b); end
    en_b = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en_c = 1;
    repeat (308) tick();
    tests++; if (x_c !== 11'd20 || y_c !== 11'd12 || hs_c !== 1'b1 || vs_c !== 1'b1) begin fails++; $display("FAIL mid_pre: got %0d,%0d hs=%b vs=%b want 20,12,1,1", x_c, y_c, hs_c, vs_c); end
    #5 rst_n = 0;
    #1;
    tests++; if (x_c !== 11'd0 || y_c !== 11'd0) begin fails++; $display("FAIL mid_async_xy: got %0d,%0d want 0,0", x_c, y_c); end
    tests++; if (hs_c !== 1'b0 || vs_c !== 1'b0 || bl_c !== 1'b0) begin fails++; $display("FAIL mid_async_out: got hs=%b vs=%b bl=%b want 0,0,0", hs_c, vs_c, bl_c); end
    tests++; if (ls_c !== 1'b0 || fs_c !== 1'b0) begin fails++; $display("FAIL mid_async_strobe: got ls=%b fs=%b want 0,0", ls_c, fs_c); end
    rst_n = 1;
    #1;
    tests++; if (ls_c !== 1'b1 || fs_c !== 1'b1) begin fails++; $display("FAIL mid_release_strobe: got ls=%b fs=%b want 1,1", ls_c, fs_c); end
    tick();
    tests++; if (x_c !== 11'd1 || y_c !== 11'd0 || hs_c !== 1'b0 || vs_c !== 1'b0) begin fails++; $display("FAIL mid_restart_count: got %0d,%0d hs=%b vs=%b want 1,0,0,0", x_c, y_c, hs_c, vs_c); end
    en_c = 0;
  endtask

  initial begin
    test_reset();
    test_hline();
    test_frame();
    test_en_toggle();
    test_restart();
    test_small_pol();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
